// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time and holds the
// fetched instruction in a one-entry output register for the control decoder.
//
// state  | meaning
// S_REQ  | request fetch_pc while the output register is (or is becoming) empty
// S_WAIT | request accepted, waiting for the response to load
// S_DROP | a redirect hit an in-flight request; discard its response
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct75,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic [31:0] instr_next, pc_next;
  logic        valid_next;
  logic        out_free, accept, load;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_REQ;
    else        state <= state_next;
  end

  always_comb begin
    out_free   = !instr_valid || instr_ready;
    imem_req   = rst_n && (state == S_REQ) && out_free;
    imem_addr  = fetch_pc;
    accept     = imem_req && imem_ready;
    load       = (state == S_WAIT) && imem_rvalid && !PCSrc;
    state_next = state;
    case (state)
      S_REQ:   if (accept) state_next = PCSrc ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)  state_next = S_REQ;
        else if (PCSrc)   state_next = S_DROP;
      end
      S_DROP:  if (imem_rvalid) state_next = S_REQ;
      default: state_next = S_REQ;
    endcase
  end

  // Redirect wins over load and consume; the target is forced word-aligned.
  always_comb begin
    fetch_pc_next = fetch_pc;
    valid_next    = instr_valid;
    instr_next    = instr;
    pc_next       = pc;
    if (PCSrc) begin
      fetch_pc_next = PCTarget & 32'hFFFF_FFFC;
      valid_next    = 1'b0;
    end else if (load) begin
      fetch_pc_next = fetch_pc + 32'd4;
      valid_next    = 1'b1;
      instr_next    = imem_rdata;
      pc_next       = fetch_pc;
    end else if (instr_valid && instr_ready) begin
      valid_next    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= 32'h0000_0013;
      pc          <= RESET_PC;
    end else begin
      fetch_pc    <= fetch_pc_next;
      instr_valid <= valid_next;
      instr       <= instr_next;
      pc          <= pc_next;
    end
  end

  assign op      = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct75 = instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic, all checked
// every cycle against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct75;
  logic        PCSrc;
  logic [31:0] PCTarget;

  logic        w_req, w_valid, w_f75;
  logic [31:0] w_addr, w_instr, w_pc;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc),
    .op(op), .funct3(funct3), .funct75(funct75), .PCSrc(PCSrc), .PCTarget(PCTarget)
  );

  // Second instance shares the stimulus; only its reset-time addresses are checked.
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(w_valid), .instr_ready(instr_ready), .instr(w_instr), .pc(w_pc),
    .op(w_op), .funct3(w_f3), .funct75(w_f75), .PCSrc(PCSrc), .PCTarget(PCTarget)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: output register contents, next address to fetch, and the single
  // outstanding memory transaction (poisoned if any redirect overlapped it).
  logic        m_valid, m_out, m_poison;
  logic [31:0] m_instr, m_pc, m_next, m_addr;
  int          m_cnt;
  int          lat_lo = 1, lat_hi = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    logic        exp_req, accept, deliver;
    logic [31:0] bus_addr;
    if (!rst_n) begin
      chk("req_in_reset", imem_req, 1'b0);
      m_valid = 1'b0; m_instr = 32'h13; m_pc = 32'h0; m_next = 32'h0;
      m_out = 1'b0; m_poison = 1'b0;
      return;
    end
    exp_req = !m_out && (!m_valid || instr_ready);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_next);
    chk("instr_valid", instr_valid, m_valid);
    if (m_valid) begin
      chk("instr", instr, m_instr);
      chk("pc", pc, m_pc);
      chk("op", op, m_instr[6:0]);
      chk("funct3", funct3, m_instr[14:12]);
      chk("funct75", funct75, m_instr[30]);
    end
    bus_addr = m_next;
    accept   = exp_req && imem_ready;
    deliver  = imem_rvalid && m_out && !m_poison && !PCSrc;
    if (imem_rvalid) m_out = 1'b0;
    if (PCSrc) begin
      m_valid = 1'b0;
      m_next  = {PCTarget[31:2], 2'b00};
    end else if (deliver) begin
      m_valid = 1'b1;
      m_instr = imem_rdata;
      m_pc    = m_addr;
      m_next  = m_addr + 32'd4;
    end else if (m_valid && instr_ready) begin
      m_valid = 1'b0;
    end
    if (PCSrc && m_out) m_poison = 1'b1;
    if (accept) begin
      m_out    = 1'b1;
      m_addr   = bus_addr;
      m_poison = PCSrc;
      m_cnt    = $urandom_range(lat_hi, lat_lo);
    end
  endtask

  // One clock cycle: apply inputs after the rising edge, answer from the memory model,
  // then check and advance the model at the falling edge.
  task automatic cyc(input logic rst, input logic mrdy, input logic irdy,
                     input logic psrc, input logic [31:0] tgt);
    @(posedge clk); #1;
    rst_n = rst; imem_ready = mrdy; instr_ready = irdy; PCSrc = psrc; PCTarget = tgt;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (m_out) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(m_addr);
      end
    end
    @(negedge clk);
    model_step();
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0;
    m_valid = 1'b0; m_out = 1'b0; m_poison = 1'b0; m_cnt = 0;
    m_instr = 32'h13; m_pc = 32'h0; m_next = 32'h0; m_addr = 32'h0;

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // c0: first fetch straight out of reset
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("c0_req", imem_req, 1'b1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_valid", instr_valid, 1'b0);
    chk("wrap_c0_addr", w_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    // c2..c6: first instruction held under backpressure
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("bp_valid", instr_valid, 1'b1);
      chk("bp_req", imem_req, 1'b0);
      chk("bp_pc", pc, 32'h0);
      chk("bp_instr", instr, 32'h0050_0093);
      if (i == 0) begin
        chk("c2_op", op, 7'h13);
        chk("c2_funct3", funct3, 3'd0);
        chk("wrap_c2_valid", w_valid, 1'b1);
        chk("wrap_c2_pc", w_pc, 32'hFFFF_FFFC);
      end
    end
    // c7: consume, next request issues in the same cycle
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("c7_req", imem_req, 1'b1);
    chk("c7_addr", imem_addr, 32'h4);
    chk("wrap_c7_addr", w_addr, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    // c9: deliver pc 4 and request 8 with a slow memory
    lat_lo = 3; lat_hi = 3;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("c9_pc", pc, 32'h4);
    chk("c9_addr", imem_addr, 32'h8);
    lat_lo = 1; lat_hi = 1;
    // c10: redirect while waiting
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk("drop_valid", instr_valid, 1'b0);
      chk("drop_req", imem_req, 1'b0);
    end
    // c13: fetch from redirect target
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("c13_valid", instr_valid, 1'b0);
    chk("c13_addr", imem_addr, 32'h100);
    // c14: redirect coincident with the response
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
    chk("c14_rvalid", imem_rvalid, 1'b1);
    // c15: redirect coincident with acceptance; unaligned target
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h103);
    chk("c15_valid", instr_valid, 1'b0);
    chk("c15_addr", imem_addr, 32'h200);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("c16_valid", instr_valid, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("c17_valid", instr_valid, 1'b0);
    chk("c17_addr", imem_addr, 32'h100);
    // c18: reset lands with the response that would fill the register
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    // Randomized traffic with variable memory latency, redirects and resets.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 299) != 0), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 11) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
